// File: rtl/alu_issuer_if.sv
// Signal bundle between alu_issuer and its environment: request stream, ALU
// issue/return lines, response stream and status.
interface alu_issuer_if #(
  parameter int unsigned WIDTH = 6
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_out;
  logic             alu_out_valid;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_out, alu_out_valid, rsp_ready,
    output req_ready, alu_op, alu_a, alu_b, alu_valid, rsp_valid, rsp_data,
           busy, err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_out, alu_out_valid, rsp_ready,
    input  req_ready, alu_op, alu_a, alu_b, alu_valid, rsp_valid, rsp_data,
           busy, err
  );
endinterface

// File: rtl/alu_issuer.sv
// Request-side initiator for the alu pipeline with credit-protected in-order
// response FIFO. Define ALU_ISSUER_CHECK_EN to build the result checker (err).
module alu_issuer #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  alu_issuer_if.slave  bus
);
  localparam int unsigned  AW      = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic             alu_valid_q;
  logic [1:0]       alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [1:0]       inflight_q, inflight_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          accept;
  logic          ret;
  logic          pop;
  logic [AW+1:0] used;

  // Credits cover both buffered and in-flight results, so a return always has a slot.
  assign used          = (AW+2)'(count_q) + (AW+2)'(inflight_q);
  assign bus.req_ready = !rst && (used < DEPTH_W);
  assign accept        = bus.req_valid && bus.req_ready;
  assign ret           = !rst && bus.alu_out_valid && (inflight_q != 2'd0);
  assign pop           = (count_q != '0) && bus.rsp_ready;

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, ret})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
    count_d = count_q;
    case ({ret, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      alu_valid_q <= accept;
      if (accept) begin
        alu_op_q <= bus.req_op;
        alu_a_q  <= bus.req_a;
        alu_b_q  <= bus.req_b;
      end
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (ret) wptr_q <= wptr_q + PTR_ONE;
      if (pop) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (ret) mem_q[wptr_q] <= bus.alu_out;
  end

  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_data  = mem_q[rptr_q];
  assign bus.busy      = (inflight_q != 2'd0) || (count_q != '0);

`ifdef ALU_ISSUER_CHECK_EN
  logic [WIDTH-1:0] exp_q [4];
  logic [1:0]       ewp_q, erp_q;
  logic             err_q;

  function automatic logic [WIDTH-1:0] expect_result(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return '0;
    endcase
  endfunction

  // inflight never exceeds 3, so a 4-entry ring cannot overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      ewp_q <= '0;
      erp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        exp_q[ewp_q] <= expect_result(bus.req_op, bus.req_a, bus.req_b);
        ewp_q        <= ewp_q + 2'd1;
      end
      if (ret) begin
        erp_q <= erp_q + 2'd1;
        if (bus.alu_out != exp_q[erp_q]) err_q <= 1'b1;
      end
      if (bus.alu_out_valid && (inflight_q == 2'd0)) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: behavioural ALU, queue-based reference
// model, directed steps followed by a randomized phase.
module tb_alu_issuer;
  localparam int unsigned W = 6;
  localparam int unsigned D = 4;
  localparam int unsigned MOD = 1 << W;
`ifdef ALU_ISSUER_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issuer_if #(.WIDTH(W)) bus ();

  alu_issuer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [W-1:0] flip = '0;
  logic [W-1:0] sb[$];
  logic [W-1:0] rsp_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_result(input int op, input int a, input int b);
    int r;
    if (op == 1)      r = (a + b) % MOD;
    else if (op == 2) r = (a - b + MOD) % MOD;
    else              r = 0;
    return W'(r);
  endfunction

  // Two-stage ALU model sharing rst; flip corrupts results for the error test.
  logic         s1_v;
  logic [W-1:0] s1_r;
  always @(posedge clk) begin
    if (rst) begin
      s1_v              <= 1'b0;
      s1_r              <= '0;
      bus.alu_out_valid <= 1'b0;
      bus.alu_out       <= '0;
    end else begin
      s1_v <= bus.alu_valid;
      case (bus.alu_op)
        2'd1:    s1_r <= (bus.alu_a + bus.alu_b) ^ flip;
        2'd2:    s1_r <= (bus.alu_a - bus.alu_b) ^ flip;
        default: s1_r <= '0 ^ flip;
      endcase
      bus.alu_out_valid <= s1_v;
      bus.alu_out       <= s1_r;
    end
  end

  // Outstanding requests = accepted minus consumed; that alone decides credit and busy.
  always @(posedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      check("req_ready_credit", bus.req_ready, sb.size() < D);
      check("busy", bus.busy, sb.size() != 0);
      if (sb.size() == 0) check("rsp_valid_empty", bus.rsp_valid, 0);
      if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_data", bus.rsp_data, e);
        rsp_log.push_back(bus.rsp_data);
      end
      if (bus.req_valid && bus.req_ready)
        sb.push_back(ref_result(bus.req_op, bus.req_a, bus.req_b) ^ flip);
    end
  end

  task automatic set_req(input int op, input int a, input int b);
    bus.req_op = op[1:0];
    bus.req_a  = a[W-1:0];
    bus.req_b  = b[W-1:0];
  endtask

  task automatic send(input int op, input int a, input int b);
    bit done = 1'b0;
    set_req(op, a, b);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      @(posedge clk);
    end
    #1 bus.req_valid = 1'b0;
    check("send_accept", done, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) idle = 1'b1;
    end
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    int lat;
    int idx;
    bit rdy;
    bit seen;

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 0, 0);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_valid", bus.alu_valid, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", bus.req_ready, 1);

    // Single add: latency and forwarded issue registers.
    bus.rsp_ready = 1'b1;
    send(1, 50, 20);
    check("issue_valid", bus.alu_valid, 1);
    check("issue_op", bus.alu_op, 1);
    check("issue_a", bus.alu_a, 50);
    check("issue_b", bus.alu_b, 20);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check("issue_valid_drop", bus.alu_valid, 0);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("add_latency", lat, 3);
    check("add_data", bus.rsp_data, 6);
    wait_idle();

    rsp_log.delete();
    send(2, 5, 9);
    wait_idle();
    check("sub_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check("sub_data", rsp_log[0], 60);

    rsp_log.delete();
    send(0, 7, 7);
    wait_idle();
    check("nop_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) check("nop_data", rsp_log[0], 0);

    // Back-to-back stream; acceptance paced only by credits.
    rsp_log.delete();
    for (int i = 0; i < 8; i++) send(1, i, i + 1);
    wait_idle();
    check("b2b_count", rsp_log.size(), 8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++) check("b2b_data", rsp_log[i], 2 * i + 1);

    // Backpressure: only DEPTH requests accepted while responses are held.
    rsp_log.delete();
    bus.rsp_ready = 1'b0;
    idx = 0;
    set_req(1, 10, 3);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) idx++;
      #1;
      if (idx < 6) set_req(1, 10 + idx, 3);
      else bus.req_valid = 1'b0;
    end
    check("credit_accepts", idx, 4);
    check("credit_ready_low", bus.req_ready, 0);
    check("credit_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      if (rdy) idx++;
      #1;
      if (idx < 6) set_req(1, 10 + idx, 3);
      else bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check("credit_total", idx, 6);
    wait_idle();
    check("credit_rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < 6 && i < rsp_log.size(); i++) check("credit_data", rsp_log[i], 13 + i);

    // Reset with three requests in flight.
    rsp_log.delete();
    send(1, 1, 1);
    send(1, 2, 2);
    send(1, 3, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_alu_valid", bus.alu_valid, 0);
    check("mid_rst_alu_op", bus.alu_op, 0);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_alu_b", bus.alu_b, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", bus.req_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_rsp", rsp_log.size(), 0);
    check("post_rst_busy", bus.busy, 0);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'($urandom_range(1));
      set_req(int'($urandom_range(3)), int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)));
      bus.rsp_ready = ($urandom_range(3) != 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("rand_drained", sb.size(), 0);
    check("rand_err", bus.err, 0);

    // Corrupted return: checker flags it and holds until reset.
    flip = W'(1);
    send(1, 3, 4);
    wait_idle();
    flip = '0;
    check("err_set", bus.err, ERR_EXP);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", bus.err, ERR_EXP);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("err_cleared", bus.err, 0);
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
